// File: rtl/ram_pkg.sv
// ram_pkg -- shared definitions for the parameterised RAM.
//   DEF_DATA_W / DEF_ADDR_W : default word and address widths
//   state_t                 : controller states (INIT sweep, IDLE service)
package ram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

endpackage

// File: rtl/ram_core.sv
// ram_core -- storage array with one write port and one registered read port.
// No reset: contents are only ever changed through the write port.
// Ports:
//   clk   : clock
//   we    : write enable, wdata stored at mem[waddr] on the rising edge
//   waddr : write address
//   wdata : write data
//   re    : read enable, rdata loads mem[raddr] on the rising edge
//   raddr : read address
//   rdata : registered read data, holds between reads
module ram_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 2**ADDR_W
)(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/param_ram.sv
// param_ram -- parameterised single-port RAM with a power-up clearing sweep.
// After reset the controller writes INIT_VALUE to every location (Busy=1),
// then services read/write requests with one cycle of read latency.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   Address : request word address
//   DataIn  : write data
//   RW      : 1 = write, 0 = read
//   En      : request strobe
//   DataOut : registered read data (0 after reset or an out-of-range read)
//   RdValid : one-cycle pulse when DataOut carries new read data
//   AddrErr : one-cycle pulse for a request with Address >= DEPTH
//   Busy    : high while the clearing sweep runs; requests are ignored
module param_ram
    import ram_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DEPTH      = 2**ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              RW,
    input  logic              En,
    output logic [DATA_W-1:0] DataOut,
    output logic              RdValid,
    output logic              AddrErr,
    output logic              Busy
);

    // One extra bit so DEPTH == 2**ADDR_W is representable for the compare.
    localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;
    // Selects the core's read register (1) or forced zero (0) onto DataOut.
    // The core register has no reset, so zero after reset and after an
    // out-of-range read is produced by this select instead.
    logic              dout_sel_q, dout_sel_d;

    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    assign in_range = ({1'b0, Address} < DEPTH_CMP);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        dout_sel_d = dout_sel_q;
        mem_we     = 1'b0;
        mem_waddr  = Address;
        mem_wdata  = DataIn;
        mem_re     = 1'b0;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = INIT_VALUE;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (En) begin
                    if (!in_range) begin
                        addr_err_d = 1'b1;
                        if (!RW) begin
                            rd_valid_d = 1'b1;
                            dout_sel_d = 1'b0;
                        end
                    end else if (RW) begin
                        mem_we = 1'b1;
                    end else begin
                        mem_re     = 1'b1;
                        rd_valid_d = 1'b1;
                        dout_sel_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase

        // No storage activity at an edge where reset is asserted; the
        // sweep that follows reset is what clears the array.
        if (!rst_n) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            dout_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
            dout_sel_q <= dout_sel_d;
        end
    end

    ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (Address),
        .rdata (mem_rdata)
    );

    assign DataOut = dout_sel_q ? mem_rdata : '0;
    assign RdValid = rd_valid_q;
    assign AddrErr = addr_err_q;
    assign Busy    = (state_q == ST_INIT);

endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram -- self-checking bench for param_ram.
// Two instances share one stimulus stream: dut_a with default parameters
// (DEPTH 1024, INIT_VALUE 0) and dut_b with DEPTH 1000, INIT_VALUE 0x3C.
// A behavioural model (array per instance plus cycles-since-reset count)
// predicts every output after every clock edge.
module tb_param_ram;

    logic       clk;
    logic       rst_n;
    logic [9:0] Address;
    logic [7:0] DataIn;
    logic       RW;
    logic       En;

    logic [7:0] dout_a, dout_b;
    logic       rv_a, rv_b;
    logic       err_a, err_b;
    logic       busy_a, busy_b;

    int total = 0;
    int bad   = 0;

    // model state, index 0 = dut_a, 1 = dut_b
    int         depth_m [2];
    logic [7:0] init_m  [2];
    logic [7:0] mem_m   [2][1024];
    int         since_m [2];
    logic [7:0] exp_dout[2];
    logic       exp_rv  [2];
    logic       exp_err [2];
    logic       exp_busy[2];

    int na, nb;

    param_ram dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .Address (Address),
        .DataIn  (DataIn),
        .RW      (RW),
        .En      (En),
        .DataOut (dout_a),
        .RdValid (rv_a),
        .AddrErr (err_a),
        .Busy    (busy_a)
    );

    param_ram #(
        .DEPTH      (1000),
        .INIT_VALUE (8'h3C)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .Address (Address),
        .DataIn  (DataIn),
        .RW      (RW),
        .En      (En),
        .DataOut (dout_b),
        .RdValid (rv_b),
        .AddrErr (err_b),
        .Busy    (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, advance the model, then check all outputs.
    task automatic step(input logic r, input logic e, input logic w,
                        input logic [9:0] a, input logic [7:0] d, input string tag);
        rst_n   = r;
        En      = e;
        RW      = w;
        Address = a;
        DataIn  = d;
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                since_m[k]  = 0;
                exp_dout[k] = 8'h00;
                exp_rv[k]   = 1'b0;
                exp_err[k]  = 1'b0;
                exp_busy[k] = 1'b1;
                // every location is rewritten before any request is accepted
                for (int i = 0; i < 1024; i++) mem_m[k][i] = init_m[k];
            end else begin
                exp_rv[k]  = 1'b0;
                exp_err[k] = 1'b0;
                if (since_m[k] >= depth_m[k] && e) begin
                    if (int'(a) >= depth_m[k]) begin
                        exp_err[k] = 1'b1;
                        if (!w) begin
                            exp_rv[k]   = 1'b1;
                            exp_dout[k] = 8'h00;
                        end
                    end else if (w) begin
                        mem_m[k][a] = d;
                    end else begin
                        exp_rv[k]   = 1'b1;
                        exp_dout[k] = mem_m[k][a];
                    end
                end
                if (since_m[k] < depth_m[k]) since_m[k]++;
                exp_busy[k] = (since_m[k] < depth_m[k]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [7:0] od;
            logic       orv, oer, obs;
            od  = (k == 0) ? dout_a : dout_b;
            orv = (k == 0) ? rv_a   : rv_b;
            oer = (k == 0) ? err_a  : err_b;
            obs = (k == 0) ? busy_a : busy_b;
            total += 4;
            if (od !== exp_dout[k]) begin
                bad++;
                $display("FAIL %s dut%0d DataOut got=%h exp=%h", tag, k, od, exp_dout[k]);
            end
            if (orv !== exp_rv[k]) begin
                bad++;
                $display("FAIL %s dut%0d RdValid got=%b exp=%b", tag, k, orv, exp_rv[k]);
            end
            if (oer !== exp_err[k]) begin
                bad++;
                $display("FAIL %s dut%0d AddrErr got=%b exp=%b", tag, k, oer, exp_err[k]);
            end
            if (obs !== exp_busy[k]) begin
                bad++;
                $display("FAIL %s dut%0d Busy got=%b exp=%b", tag, k, obs, exp_busy[k]);
            end
        end
    endtask

    // Random requests until both instances finish sweeping (bounded),
    // accumulating observed Busy-high cycles into na / nb.
    task automatic run_sweep(input string tag);
        for (int i = 0; i < 1200 && (busy_a || busy_b); i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 10'($urandom_range(0, 1023)), 8'($urandom), tag);
            if (busy_a) na++;
            if (busy_b) nb++;
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b0, 10'd3, 8'h00, "reset");
        step(1'b0, 1'b1, 1'b1, 10'd5, 8'hFF, "reset");
        total++;
        if (busy_a !== 1'b1 || dout_a !== 8'h00 || rv_a !== 1'b0 || err_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got busy=%b dout=%h rv=%b err=%b exp busy=1 dout=00 rv=0 err=0",
                     busy_a, dout_a, rv_a, err_a);
        end
        $display("reset: busy_a=%b busy_b=%b dout_a=%h", busy_a, busy_b, dout_a);
    endtask

    task automatic test_init_sweep();
        na = busy_a ? 1 : 0;
        nb = busy_b ? 1 : 0;
        // a read while busy must be ignored
        step(1'b1, 1'b1, 1'b0, 10'd3, 8'h00, "busy_read");
        if (busy_a) na++;
        if (busy_b) nb++;
        total++;
        if (rv_a !== 1'b0 || rv_b !== 1'b0) begin
            bad++;
            $display("FAIL busy_read RdValid got a=%b b=%b exp 0", rv_a, rv_b);
        end
        run_sweep("sweep");
        total += 2;
        if (na !== 1024) begin
            bad++;
            $display("FAIL busy_len_a got=%0d exp=1024", na);
        end
        if (nb !== 1000) begin
            bad++;
            $display("FAIL busy_len_b got=%0d exp=1000", nb);
        end
        $display("sweep: busy cycles a=%0d b=%0d", na, nb);
        step(1'b1, 1'b1, 1'b0, 10'h000, 8'h00, "rd_000");
        step(1'b1, 1'b1, 1'b0, 10'h003, 8'h00, "rd_003");
        step(1'b1, 1'b1, 1'b0, 10'h3FF, 8'h00, "rd_3ff");
        total++;
        if (dout_a !== 8'h00 || rv_a !== 1'b1) begin
            bad++;
            $display("FAIL rd_3ff_a got dout=%h rv=%b exp dout=00 rv=1", dout_a, rv_a);
        end
    endtask

    task automatic test_write_read();
        step(1'b1, 1'b1, 1'b1, 10'd3, 8'hAA, "wr_aa");
        step(1'b1, 1'b1, 1'b0, 10'd3, 8'h00, "rd_aa");
        total++;
        if (dout_a !== 8'hAA || rv_a !== 1'b1 || dout_b !== 8'hAA) begin
            bad++;
            $display("FAIL rd_aa got a=%h rv=%b b=%h exp AA rv=1", dout_a, rv_a, dout_b);
        end
        step(1'b1, 1'b0, 1'b1, 10'd3, 8'hF0, "en0_wr");
        total++;
        if (rv_a !== 1'b0 || dout_a !== 8'hAA) begin
            bad++;
            $display("FAIL en0_hold got dout=%h rv=%b exp dout=AA rv=0", dout_a, rv_a);
        end
        step(1'b1, 1'b1, 1'b0, 10'd3, 8'h00, "rd_after_en0");
        total++;
        if (dout_a !== 8'hAA) begin
            bad++;
            $display("FAIL rd_after_en0 got=%h exp=AA", dout_a);
        end
        step(1'b1, 1'b1, 1'b1, 10'h3FF, 8'h55, "wr_55");
        step(1'b1, 1'b1, 1'b0, 10'h3FF, 8'h00, "rd_55");
        total++;
        if (dout_a !== 8'h55 || dout_b !== 8'h00 || err_b !== 1'b1) begin
            bad++;
            $display("FAIL rd_55 got a=%h b=%h err_b=%b exp a=55 b=00 err_b=1", dout_a, dout_b, err_b);
        end
        $display("write_read: a=%h b=%h", dout_a, dout_b);
    endtask

    task automatic test_range();
        step(1'b1, 1'b1, 1'b1, 10'd1000, 8'h77, "wr_1000");
        total++;
        if (err_b !== 1'b1 || err_a !== 1'b0 || rv_b !== 1'b0) begin
            bad++;
            $display("FAIL wr_1000 got err_b=%b err_a=%b rv_b=%b exp 1 0 0", err_b, err_a, rv_b);
        end
        step(1'b1, 1'b0, 1'b0, 10'd0, 8'h00, "err_pulse");
        total++;
        if (err_b !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse got=%b exp=0", err_b);
        end
        step(1'b1, 1'b1, 1'b0, 10'd1000, 8'h00, "rd_1000");
        total++;
        if (dout_b !== 8'h00 || rv_b !== 1'b1 || err_b !== 1'b1 || dout_a !== 8'h77) begin
            bad++;
            $display("FAIL rd_1000 got b=%h rv=%b err=%b a=%h exp 00 1 1 77",
                     dout_b, rv_b, err_b, dout_a);
        end
        step(1'b1, 1'b1, 1'b0, 10'd999, 8'h00, "rd_999");
        total++;
        if (dout_b !== 8'h3C || err_b !== 1'b0) begin
            bad++;
            $display("FAIL rd_999 got=%h err=%b exp=3C err=0", dout_b, err_b);
        end
        $display("range: rd_999 b=%h", dout_b);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            logic [9:0] a;
            logic [7:0] d;
            a = 10'($urandom_range(0, 999));
            d = 8'($urandom);
            step(1'b1, 1'b1, 1'b1, a, d, "b2b_wr");
            step(1'b1, 1'b1, 1'b0, a, 8'h00, "b2b_rd");
            total++;
            if (dout_a !== d || dout_b !== d) begin
                bad++;
                $display("FAIL b2b addr=%h got a=%h b=%h exp=%h", a, dout_a, dout_b, d);
            end
        end
        $display("back_to_back: 40 pairs");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [9:0] a;
            if ($urandom_range(0, 1) == 0) a = 10'($urandom_range(0, 15));
            else                           a = 10'($urandom_range(990, 1023));
            step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 a, 8'($urandom), "random");
        end
        $display("random: 400 cycles");
    endtask

    task automatic test_reset_mid_sweep();
        step(1'b0, 1'b0, 1'b0, 10'd0, 8'h00, "mid_rst0");
        for (int i = 0; i < 500; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 10'($urandom_range(0, 1023)), 8'($urandom), "mid_pre");
        end
        step(1'b0, 1'b1, 1'b1, 10'd3, 8'h99, "mid_rst1");
        na = busy_a ? 1 : 0;
        nb = busy_b ? 1 : 0;
        run_sweep("mid_sweep");
        total += 2;
        if (na !== 1024) begin
            bad++;
            $display("FAIL mid_busy_a got=%0d exp=1024", na);
        end
        if (nb !== 1000) begin
            bad++;
            $display("FAIL mid_busy_b got=%0d exp=1000", nb);
        end
        step(1'b1, 1'b1, 1'b0, 10'd3, 8'h00, "mid_rd3");
        total++;
        if (dout_a !== 8'h00 || dout_b !== 8'h3C) begin
            bad++;
            $display("FAIL mid_rd3 got a=%h b=%h exp a=00 b=3C", dout_a, dout_b);
        end
        step(1'b1, 1'b1, 1'b0, 10'h3FF, 8'h00, "mid_rd3ff");
        total++;
        if (dout_a !== 8'h00) begin
            bad++;
            $display("FAIL mid_rd3ff got=%h exp=00", dout_a);
        end
        $display("reset_mid_sweep: busy a=%0d b=%0d", na, nb);
    endtask

    initial begin
        depth_m[0] = 1024;
        depth_m[1] = 1000;
        init_m[0]  = 8'h00;
        init_m[1]  = 8'h3C;
        since_m[0] = 0;
        since_m[1] = 0;
        rst_n   = 1'b0;
        En      = 1'b0;
        RW      = 1'b0;
        Address = '0;
        DataIn  = '0;

        test_reset();
        test_init_sweep();
        test_write_read();
        test_range();
        test_back_to_back();
        test_random();
        test_reset_mid_sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
